bsg_chip_io_link_arbiter: RTL

- Round-robin packet arbiter that shares one IO link uplink core-side port (valid / data / ready_and) among num_req_p core-side requesters.
- Sits in the core clock domain, between the requesters and the uplink's core_v_i / core_data_i / core_ready_and_o.
- Grants whole packets: a header flit carries a length field, and the grant stays locked until the last flit of that packet has been accepted.

---
 rtl/bsg_chip_io_link_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bsg_chip_io_link_arbiter.sv
// Round-robin packet arbiter in front of one IO link uplink core-side port.
// Whole packets are granted: the header's low len_width_p bits give the number
// of body flits, and the grant stays locked until the last body flit is taken.
// Ports:
//   clk_i, reset_i          core clock, synchronous active-high reset
//   req_v_i/req_data_i      per-requester flit valid / flit (flat, requester i at [i*width_p +: width_p])
//   req_ready_and_o         per-requester ready (only the granted requester can see ready)
//   link_v_o/link_data_o    flit to uplink (zero-latency mux of the granted requester)
//   link_ready_and_i        uplink ready
//   grant_id_o              selected requester (don't-care when link_v_o=0)
//   locked_o                packet in progress (header accepted, body remaining)
module bsg_chip_io_link_arbiter #(
  parameter int unsigned num_req_p   = 4,
  parameter int unsigned width_p     = 32,
  parameter int unsigned len_width_p = 4,
  localparam int unsigned id_width_lp = $clog2(num_req_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p-1:0]           req_v_i,
  input  logic [num_req_p*width_p-1:0]   req_data_i,
  output logic [num_req_p-1:0]           req_ready_and_o,
  output logic                           link_v_o,
  output logic [width_p-1:0]             link_data_o,
  input  logic                           link_ready_and_i,
  output logic [id_width_lp-1:0]         grant_id_o,
  output logic                           locked_o
);

  typedef enum logic [1:0] {IDLE, HOLD, BUSY} state_e;

  state_e                   state_r, state_n;
  logic [id_width_lp-1:0]   rr_ptr_r, rr_ptr_n;
  logic [id_width_lp-1:0]   grant_r, grant_n;
  logic [len_width_p-1:0]   cnt_r, cnt_n;

  logic [id_width_lp-1:0]   winner;
  logic                     any_v;
  logic [id_width_lp-1:0]   grant;
  logic                     has_grant;
  logic                     xfer;
  logic [len_width_p-1:0]   hdr_len;
  int unsigned              idx;

  // Modulo-num_req_p increment; works for non-power-of-2 counts.
  function automatic logic [id_width_lp-1:0] next_id(input logic [id_width_lp-1:0] g);
    return (g == id_width_lp'(num_req_p - 1)) ? '0 : g + id_width_lp'(1);
  endfunction

  // Circular priority search starting at rr_ptr_r.
  always_comb begin
    winner = '0;
    any_v  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      idx = 32'(rr_ptr_r) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!any_v && req_v_i[id_width_lp'(idx)]) begin
        any_v  = 1'b1;
        winner = id_width_lp'(idx);
      end
    end
  end

  // Only IDLE arbitrates freely; HOLD and BUSY keep the registered grant.
  always_comb begin
    grant     = grant_r;
    has_grant = 1'b1;
    if (state_r == IDLE) begin
      grant     = winner;
      has_grant = any_v;
    end
  end

  // Pure data mux: no storage between requester and link.
  always_comb begin
    link_data_o = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (grant == id_width_lp'(i)) link_data_o = req_data_i[i*width_p +: width_p];
    end
  end

  always_comb begin
    link_v_o   = has_grant & req_v_i[grant] & ~reset_i;
    grant_id_o = grant;
    locked_o   = (state_r == BUSY) & ~reset_i;
    xfer       = link_v_o & link_ready_and_i;
    hdr_len    = link_data_o[len_width_p-1:0];
    for (int unsigned i = 0; i < num_req_p; i++) begin
      req_ready_and_o[i] = link_ready_and_i & has_grant & ~reset_i & (grant == id_width_lp'(i));
    end
  end

  // Next-state logic.
  always_comb begin
    state_n  = state_r;
    rr_ptr_n = rr_ptr_r;
    grant_n  = grant_r;
    cnt_n    = cnt_r;
    case (state_r)
      IDLE: begin
        if (any_v) begin
          grant_n = winner;
          if (xfer) begin
            if (hdr_len == '0) begin
              rr_ptr_n = next_id(winner);
            end else begin
              state_n = BUSY;
              cnt_n   = hdr_len;
            end
          end else begin
            // Freeze the offered header until the link takes it.
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (!req_v_i[grant_r]) begin
          state_n = IDLE;
        end else if (xfer) begin
          if (hdr_len == '0) begin
            state_n  = IDLE;
            rr_ptr_n = next_id(grant_r);
          end else begin
            state_n = BUSY;
            cnt_n   = hdr_len;
          end
        end
      end
      BUSY: begin
        // cnt_r >= 1 throughout BUSY, so the decrement cannot underflow.
        if (xfer) begin
          cnt_n = cnt_r - len_width_p'(1);
          if (cnt_r == len_width_p'(1)) begin
            state_n  = IDLE;
            rr_ptr_n = next_id(grant_r);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= IDLE;
      rr_ptr_r <= '0;
      grant_r  <= '0;
      cnt_r    <= '0;
    end else begin
      state_r  <= state_n;
      rr_ptr_r <= rr_ptr_n;
      grant_r  <= grant_n;
      cnt_r    <= cnt_n;
    end
  end

endmodule
